// File: rtl/button_conditioner.sv
// Button conditioner: per-channel debounce of synchronized button levels with
// registered press, release and one-shot long-press event pulses.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_sync,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int LG_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

  function automatic logic [LG_W-1:0] hold_sat_inc(input logic [LG_W-1:0] v);
    hold_sat_inc = (v == LG_LAST) ? v : v + 1'b1;
  endfunction

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [LG_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            long_q, long_d;
    logic            done_q, done_d;

    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (btn_sync[i] != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = btn_sync[i];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      // Hold count is zero in any cycle where the level reads 0, including
      // the release cycle itself.
      hold_cnt_d = (level_q && level_d) ? hold_sat_inc(hold_cnt_q) : '0;

      press_d = level_d & ~level_q;
      rel_d   = level_q & ~level_d;

      // done_q keeps the saturated counter from re-firing; a release on the
      // firing edge suppresses the long pulse.
      long_d = level_q && level_d && (hold_cnt_q == LG_LAST) && !done_q;
      done_d = level_d && (done_q || long_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
        long_q     <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        rel_q      <= rel_d;
        long_q     <= long_d;
        done_q     <= done_d;
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign long_pulse[i]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 8, LONG_CYCLES = 32.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_sync = 4'h0;
  logic [3:0] btn_level, press_pulse, release_pulse, long_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_sync(btn_sync),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_sync = 4'hF;
    #23;
    n_checks++; if (btn_level !== 4'h0) $display("FAIL reset_level got %h want 0", btn_level); else n_pass++;
    n_checks++; if (press_pulse !== 4'h0) $display("FAIL reset_press got %h want 0", press_pulse); else n_pass++;
    n_checks++; if (release_pulse !== 4'h0) $display("FAIL reset_release got %h want 0", release_pulse); else n_pass++;
    n_checks++; if (long_pulse !== 4'h0) $display("FAIL reset_long got %h want 0", long_pulse); else n_pass++;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    n_checks++; if (btn_level !== 4'h0) $display("FAIL rst_edge7_level got %h want 0", btn_level); else n_pass++;
    tick();
    n_checks++; if (btn_level !== 4'hF) $display("FAIL rst_edge8_level got %h want f", btn_level); else n_pass++;
    n_checks++; if (press_pulse !== 4'hF) $display("FAIL rst_edge8_press got %h want f", press_pulse); else n_pass++;
    n_checks++; if (release_pulse !== 4'h0) $display("FAIL rst_edge8_release got %h want 0", release_pulse); else n_pass++;
    tick();
    n_checks++; if (press_pulse !== 4'h0) $display("FAIL rst_press_width got %h want 0", press_pulse); else n_pass++;
    btn_sync = 4'h0;
    repeat (8) tick();
    n_checks++; if (btn_level !== 4'h0) $display("FAIL rst_rel_level got %h want 0", btn_level); else n_pass++;
    n_checks++; if (release_pulse !== 4'hF) $display("FAIL rst_rel_pulse got %h want f", release_pulse); else n_pass++;
    tick();
    n_checks++; if (release_pulse !== 4'h0) $display("FAIL rst_rel_width got %h want 0", release_pulse); else n_pass++;
  endtask

  task automatic test_bounce();
    int p_cnt = 0, p_at = -1, r_at = -1, l_cnt = 0, other = 0;
    for (int i = 1; i <= 26; i++) begin
      btn_sync[1] = (i == 6) ? 1'b0 : 1'b1;
      tick();
      if (press_pulse[1]) begin p_cnt++; p_at = i; end
      if (long_pulse[1]) l_cnt++;
      if ((press_pulse | release_pulse | long_pulse) & 4'b1101) other++;
    end
    n_checks++; if (p_cnt !== 1) $display("FAIL bounce_press_count got %0d want 1", p_cnt); else n_pass++;
    n_checks++; if (p_at !== 14) $display("FAIL bounce_press_time got %0d want 14", p_at); else n_pass++;
    n_checks++; if (btn_level[1] !== 1'b1) $display("FAIL bounce_level got %b want 1", btn_level[1]); else n_pass++;
    btn_sync[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (release_pulse[1]) r_at = i;
      if (long_pulse[1]) l_cnt++;
      if ((press_pulse | release_pulse | long_pulse) & 4'b1101) other++;
    end
    n_checks++; if (r_at !== 8) $display("FAIL bounce_release_time got %0d want 8", r_at); else n_pass++;
    n_checks++; if (l_cnt !== 0) $display("FAIL bounce_long_count got %0d want 0", l_cnt); else n_pass++;
    n_checks++; if (other !== 0) $display("FAIL bounce_cross_chan got %0d want 0", other); else n_pass++;
  endtask

  task automatic test_short_tap();
    int p_cnt = 0, p_at = -1, r_cnt = 0, r_at = -1, l_cnt = 0;
    btn_sync[2] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (press_pulse[2]) begin p_cnt++; p_at = i; end
      if (long_pulse[2]) l_cnt++;
    end
    btn_sync[2] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (release_pulse[2]) begin r_cnt++; r_at = i; end
      if (press_pulse[2]) p_cnt++;
      if (long_pulse[2]) l_cnt++;
    end
    n_checks++; if (p_cnt !== 1 || p_at !== 8) $display("FAIL tap_press got cnt=%0d at=%0d want cnt=1 at=8", p_cnt, p_at); else n_pass++;
    n_checks++; if (r_cnt !== 1 || r_at !== 8) $display("FAIL tap_release got cnt=%0d at=%0d want cnt=1 at=8", r_cnt, r_at); else n_pass++;
    n_checks++; if (l_cnt !== 0) $display("FAIL tap_long got %0d want 0", l_cnt); else n_pass++;
  endtask

  task automatic test_long_hold();
    int p_at = -1, l_cnt = 0, l_at = -1, r_at = -1;
    btn_sync[3] = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (press_pulse[3]) p_at = i;
      if (long_pulse[3]) begin l_cnt++; l_at = i; end
    end
    btn_sync[3] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (release_pulse[3]) r_at = i;
      if (long_pulse[3]) l_cnt++;
    end
    n_checks++; if (p_at !== 8) $display("FAIL long_press_time got %0d want 8", p_at); else n_pass++;
    n_checks++; if (l_at !== 40) $display("FAIL long_pulse_time got %0d want 40", l_at); else n_pass++;
    n_checks++; if (l_cnt !== 1) $display("FAIL long_pulse_count got %0d want 1", l_cnt); else n_pass++;
    n_checks++; if (r_at !== 8) $display("FAIL long_release_time got %0d want 8", r_at); else n_pass++;
  endtask

  task automatic test_independent();
    int p0 = -1, p3 = -1, r0 = -1, r3 = -1, pc = 0, rc = 0, other = 0;
    for (int t = 0; t < 40; t++) begin
      if (t == 0)  btn_sync[0] = 1'b1;
      if (t == 3)  btn_sync[3] = 1'b1;
      if (t == 15) btn_sync[0] = 1'b0;
      if (t == 20) btn_sync[3] = 1'b0;
      tick();
      if (press_pulse[0]) begin p0 = t; pc++; end
      if (press_pulse[3]) begin p3 = t; pc++; end
      if (release_pulse[0]) begin r0 = t; rc++; end
      if (release_pulse[3]) begin r3 = t; rc++; end
      if ((press_pulse | release_pulse) & 4'b0110) other++;
      if (long_pulse != 4'h0) other++;
    end
    n_checks++; if (p0 !== 7) $display("FAIL indep_press0 got %0d want 7", p0); else n_pass++;
    n_checks++; if (p3 !== 10) $display("FAIL indep_press3 got %0d want 10", p3); else n_pass++;
    n_checks++; if (r0 !== 22) $display("FAIL indep_release0 got %0d want 22", r0); else n_pass++;
    n_checks++; if (r3 !== 27) $display("FAIL indep_release3 got %0d want 27", r3); else n_pass++;
    n_checks++; if (pc !== 2 || rc !== 2) $display("FAIL indep_counts got p=%0d r=%0d want p=2 r=2", pc, rc); else n_pass++;
    n_checks++; if (other !== 0) $display("FAIL indep_cross_chan got %0d want 0", other); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int p_at = -1, p_cnt = 0, l_at = -1, l_cnt = 0;
    btn_sync[2] = 1'b1;
    repeat (8) tick();
    n_checks++; if (press_pulse[2] !== 1'b1) $display("FAIL mid_first_press got %b want 1", press_pulse[2]); else n_pass++;
    repeat (20) tick();
    rst_n = 1'b0;
    #2;
    n_checks++; if (btn_level !== 4'h0) $display("FAIL mid_rst_level got %h want 0", btn_level); else n_pass++;
    n_checks++; if ((press_pulse | release_pulse | long_pulse) !== 4'h0) $display("FAIL mid_rst_pulses got %h want 0", press_pulse | release_pulse | long_pulse); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (press_pulse[2]) begin p_cnt++; p_at = i; end
      if (long_pulse[2]) begin l_cnt++; l_at = i; end
    end
    n_checks++; if (p_cnt !== 1 || p_at !== 8) $display("FAIL mid_repress got cnt=%0d at=%0d want cnt=1 at=8", p_cnt, p_at); else n_pass++;
    n_checks++; if (l_cnt !== 1 || l_at !== 40) $display("FAIL mid_long got cnt=%0d at=%0d want cnt=1 at=40", l_cnt, l_at); else n_pass++;
    btn_sync[2] = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bounce();
    test_short_tap();
    test_long_hold();
    test_independent();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
